// File: rtl/writeback_pkg.sv
// Shared types and defaults for the writeback stage.
package writeback_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    localparam logic [2:0] LINK_REG   = 3'd7;
    localparam int         DEF_DATA_W = 16;
    localparam int         DEF_REG_AW = 3;

endpackage

// File: rtl/writeback_unit_fwd_compare.sv
// Per-operand forwarding select: matches a decode index against the wb entry
// and, when enabled by the parent, the in-flight Ex entry (Ex wins).
module fwd_compare #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] idx_i,
    input  logic              wb_valid_i,
    input  logic [REG_AW-1:0] wb_dest_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_dest_i,
    input  logic [DATA_W-1:0] ex_data_i,
    output logic              sel_o,
    output logic [DATA_W-1:0] data_o
);

    logic ex_hit, wb_hit;

    assign ex_hit = ex_valid_i && (ex_dest_i == idx_i);
    assign wb_hit = wb_valid_i && (wb_dest_i == idx_i);
    assign sel_o  = ex_hit || wb_hit;
    assign data_o = ex_hit ? ex_data_i : wb_data_i;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results, runs req/ack data loads, forwards to decode.
// Optional macro WB_EX_BYPASS_EN adds forwarding of the current-cycle ALU result.
module writeback_unit
    import writeback_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ExValid,
    input  logic              ExIsLoad,
    input  logic [REG_AW-1:0] ExDest,
    input  logic [DATA_W-1:0] ExResult,
    input  logic [DATA_W-1:0] ExAddr,
    output logic              MemReq,
    output logic [DATA_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRdData,
    input  logic [REG_AW-1:0] DecRs,
    input  logic [REG_AW-1:0] DecRt,
    output logic              WrEn,
    output logic [REG_AW-1:0] WrAddr,
    output logic [DATA_W-1:0] DataIn,
    output logic              ForwardRs,
    output logic              ForwardRt,
    output logic [DATA_W-1:0] RsForwarding,
    output logic [DATA_W-1:0] RtForwarding,
    output logic              Stall,
    output logic              MemTimeout
);

    localparam int NUM_SRC = 2;
    localparam int CNT_W   = $clog2(MAX_WAIT + 1);

    wb_state_e         state_q, state_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [REG_AW-1:0] ld_dest_q, ld_dest_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              stall_q, stall_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            ld_dest_q  <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            stall_q    <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
            ld_dest_q  <= ld_dest_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wb_valid_d = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        ld_dest_d  = ld_dest_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        stall_d    = stall_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (ExValid && !ExIsLoad) begin
                    wb_valid_d = 1'b1;
                    wb_dest_d  = ExDest;
                    wb_data_d  = ExResult;
                end else if (ExValid && ExIsLoad) begin
                    mem_addr_d = ExAddr;
                    ld_dest_d  = ExDest;
                    mem_req_d  = 1'b1;
                    stall_d    = 1'b1;
                    cnt_d      = '0;
                    state_d    = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                // An ack on the final wait cycle takes precedence over the timeout.
                if (MemAck) begin
                    wb_valid_d = 1'b1;
                    wb_dest_d  = ld_dest_q;
                    wb_data_d  = MemRdData;
                    mem_req_d  = 1'b0;
                    stall_d    = 1'b0;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                    wb_valid_d = 1'b1;
                    wb_dest_d  = ld_dest_q;
                    wb_data_d  = '0;
                    timeout_d  = 1'b1;
                    mem_req_d  = 1'b0;
                    stall_d    = 1'b0;
                    state_d    = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign WrEn       = wb_valid_q;
    assign WrAddr     = wb_dest_q;
    assign DataIn     = wb_data_q;
    assign MemReq     = mem_req_q;
    assign MemAddr    = mem_addr_q;
    assign Stall      = stall_q;
    assign MemTimeout = timeout_q;

    logic ex_fwd_vld;
`ifdef WB_EX_BYPASS_EN
    assign ex_fwd_vld = ExValid && !ExIsLoad && (state_q == IDLE);
`else
    assign ex_fwd_vld = 1'b0;
`endif

    logic [NUM_SRC-1:0][REG_AW-1:0] dec_idx;
    logic [NUM_SRC-1:0]             fwd_sel;
    logic [NUM_SRC-1:0][DATA_W-1:0] fwd_data;

    assign dec_idx = {DecRt, DecRs};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_compare #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_fwd (
            .idx_i      (dec_idx[i]),
            .wb_valid_i (wb_valid_q),
            .wb_dest_i  (wb_dest_q),
            .wb_data_i  (wb_data_q),
            .ex_valid_i (ex_fwd_vld),
            .ex_dest_i  (ExDest),
            .ex_data_i  (ExResult),
            .sel_o      (fwd_sel[i]),
            .data_o     (fwd_data[i])
        );
    end

    assign ForwardRs    = fwd_sel[0];
    assign ForwardRt    = fwd_sel[1];
    assign RsForwarding = fwd_data[0];
    assign RtForwarding = fwd_data[1];

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: transaction-level model checked every cycle, plus directed literals.
module tb_writeback_unit;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int MAX_WAIT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          ExValid, ExIsLoad, MemAck;
    logic [AW-1:0] ExDest, DecRs, DecRt;
    logic [DW-1:0] ExResult, ExAddr, MemRdData;
    logic          MemReq, WrEn, ForwardRs, ForwardRt, Stall, MemTimeout;
    logic [DW-1:0] MemAddr, DataIn, RsForwarding, RtForwarding;
    logic [AW-1:0] WrAddr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    writeback_unit #(.DATA_W(DW), .REG_AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .ExValid(ExValid), .ExIsLoad(ExIsLoad), .ExDest(ExDest),
        .ExResult(ExResult), .ExAddr(ExAddr), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemAck(MemAck), .MemRdData(MemRdData), .DecRs(DecRs), .DecRt(DecRt),
        .WrEn(WrEn), .WrAddr(WrAddr), .DataIn(DataIn), .ForwardRs(ForwardRs),
        .ForwardRt(ForwardRt), .RsForwarding(RsForwarding), .RtForwarding(RtForwarding),
        .Stall(Stall), .MemTimeout(MemTimeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a pending register write and at most one outstanding load transaction.
    logic          m_wv, m_busy, m_to;
    logic [AW-1:0] m_wa, m_ldd;
    logic [DW-1:0] m_wd, m_addr;
    int            m_waited;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wv = 0; m_busy = 0; m_to = 0; m_waited = 0;
            m_wa = '0; m_wd = '0; m_addr = '0; m_ldd = '0;
        end else if (!m_busy) begin
            m_wv = ExValid && !ExIsLoad;
            if (m_wv) begin m_wa = ExDest; m_wd = ExResult; end
            if (ExValid && ExIsLoad) begin
                m_busy = 1; m_addr = ExAddr; m_ldd = ExDest; m_waited = 0;
            end
        end else begin
            m_waited++;
            m_wv = 0;
            if (MemAck) begin
                m_wv = 1; m_wa = m_ldd; m_wd = MemRdData; m_busy = 0;
            end else if (m_waited == MAX_WAIT + 1) begin
                m_wv = 1; m_wa = m_ldd; m_wd = '0; m_busy = 0; m_to = 1;
            end
        end
    end

    task automatic exp_fwd(input logic [AW-1:0] idx, output logic sel, output logic [DW-1:0] d);
        sel = m_wv && (m_wa == idx);
        d   = m_wd;
`ifdef WB_EX_BYPASS_EN
        if (!m_busy && ExValid && !ExIsLoad && ExDest == idx) begin
            sel = 1; d = ExResult;
        end
`endif
    endtask

    always @(negedge clk) begin
        logic          s;
        logic [DW-1:0] d;
        #3;
        chk("WrEn", WrEn, m_wv);
        if (m_wv) begin
            chk("WrAddr", WrAddr, m_wa);
            chk("DataIn", DataIn, m_wd);
        end
        chk("MemReq", MemReq, m_busy);
        chk("Stall", Stall, m_busy);
        if (m_busy) chk("MemAddr", MemAddr, m_addr);
        chk("MemTimeout", MemTimeout, m_to);
        exp_fwd(DecRs, s, d);
        chk("ForwardRs", ForwardRs, s);
        if (s) chk("RsForwarding", RsForwarding, d);
        exp_fwd(DecRt, s, d);
        chk("ForwardRt", ForwardRt, s);
        if (s) chk("RtForwarding", RtForwarding, d);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic ex_alu(input logic [AW-1:0] dst, input logic [DW-1:0] v);
        ExValid = 1; ExIsLoad = 0; ExDest = dst; ExResult = v;
    endtask

    task automatic ex_load(input logic [AW-1:0] dst, input logic [DW-1:0] a);
        ExValid = 1; ExIsLoad = 1; ExDest = dst; ExAddr = a;
    endtask

    task automatic ex_idle();
        ExValid = 0; ExIsLoad = 0;
    endtask

    // Runs a load through `waits` wait cycles, acking on cycle ack_at (0 = never).
    task automatic run_load(input logic [AW-1:0] dst, input logic [DW-1:0] a,
                            input int waits, input int ack_at, input logic [DW-1:0] rd);
        cyc(); ex_load(dst, a);
        for (int k = 1; k <= waits; k++) begin
            cyc();
            ex_alu(3'd6, 16'h6666);
            MemAck = (k == ack_at);
            MemRdData = rd;
            #2;
            chk("load MemReq", MemReq, 1'b1);
            chk("load Stall", Stall, 1'b1);
            chk("load MemAddr", MemAddr, a);
        end
    endtask

    initial begin
        rst = 1; ex_idle(); ExDest = '0; ExResult = '0; ExAddr = '0;
        MemAck = 0; MemRdData = '0; DecRs = 3'd0; DecRt = 3'd7;
        cyc(); cyc(); #2;
        chk("rst WrEn", WrEn, 1'b0);
        chk("rst WrAddr", WrAddr, 3'd0);
        chk("rst DataIn", DataIn, 16'h0);
        chk("rst MemReq", MemReq, 1'b0);
        chk("rst Stall", Stall, 1'b0);
        chk("rst ForwardRs", ForwardRs, 1'b0);
        chk("rst RsForwarding", RsForwarding, 16'h0);
        cyc(); rst = 0;

        // Back-to-back ALU results
        cyc(); ex_alu(3'd3, 16'h1234);
        cyc(); ex_alu(3'd5, 16'hBEEF); DecRs = 3'd3; #2;
        chk("alu0 WrEn", WrEn, 1'b1);
        chk("alu0 WrAddr", WrAddr, 3'd3);
        chk("alu0 DataIn", DataIn, 16'h1234);
        chk("alu0 ForwardRs", ForwardRs, 1'b1);
        chk("alu0 RsForwarding", RsForwarding, 16'h1234);
        cyc(); ex_idle(); DecRt = 3'd5; #2;
        chk("alu1 WrAddr", WrAddr, 3'd5);
        chk("alu1 DataIn", DataIn, 16'hBEEF);
        chk("alu1 ForwardRt", ForwardRt, 1'b1);
        chk("alu1 RtForwarding", RtForwarding, 16'hBEEF);
        cyc(); #2;
        chk("idle WrEn", WrEn, 1'b0);

        // ALU result retiring while the following load is accepted
        cyc(); ex_alu(3'd1, 16'h1111);
        cyc(); ex_load(3'd2, 16'h0040); #2;
        chk("retire WrEn", WrEn, 1'b1);
        chk("retire WrAddr", WrAddr, 3'd1);
        for (int k = 1; k <= 5; k++) begin
            cyc(); ex_alu(3'd6, 16'h6666);
            MemAck = (k == 5); MemRdData = 16'hA5A5; DecRs = 3'd6; #2;
            chk("ld MemReq", MemReq, 1'b1);
            chk("ld MemAddr", MemAddr, 16'h0040);
            chk("ld Stall", Stall, 1'b1);
            chk("ld no WrEn", WrEn, 1'b0);
        end
        cyc(); ex_idle(); MemAck = 0; DecRs = 3'd2; #2;
        chk("ld WrEn", WrEn, 1'b1);
        chk("ld WrAddr", WrAddr, 3'd2);
        chk("ld DataIn", DataIn, 16'hA5A5);
        chk("ld MemReq drop", MemReq, 1'b0);
        chk("ld Stall drop", Stall, 1'b0);
        chk("ld ForwardRs", ForwardRs, 1'b1);

        // Ack on the last wait cycle beats the timeout
        run_load(3'd1, 16'h0200, MAX_WAIT + 1, MAX_WAIT + 1, 16'h7777);
        cyc(); ex_idle(); MemAck = 0; #2;
        chk("edge WrEn", WrEn, 1'b1);
        chk("edge DataIn", DataIn, 16'h7777);
        chk("edge MemTimeout", MemTimeout, 1'b0);

        // Timeout with no ack
        run_load(3'd4, 16'h0100, MAX_WAIT + 1, 0, 16'hFFFF);
        cyc(); ex_alu(3'd6, 16'h0606); #2;
        chk("to MemTimeout", MemTimeout, 1'b1);
        chk("to WrEn", WrEn, 1'b1);
        chk("to WrAddr", WrAddr, 3'd4);
        chk("to DataIn", DataIn, 16'h0000);
        chk("to MemReq", MemReq, 1'b0);
        cyc(); ex_idle(); #2;
        chk("post-to WrAddr", WrAddr, 3'd6);
        chk("post-to DataIn", DataIn, 16'h0606);
        chk("sticky MemTimeout", MemTimeout, 1'b1);

        // Reset in the middle of a load
        cyc(); ex_load(3'd3, 16'h0300);
        cyc(); ex_idle();
        cyc(); #2;
        chk("mid MemReq", MemReq, 1'b1);
        #1 rst = 1;
        #1;
        chk("mrst MemReq", MemReq, 1'b0);
        chk("mrst Stall", Stall, 1'b0);
        chk("mrst WrEn", WrEn, 1'b0);
        chk("mrst MemTimeout", MemTimeout, 1'b0);
        chk("mrst MemAddr", MemAddr, 16'h0);
        cyc(); rst = 0;
        cyc(); MemAck = 1; MemRdData = 16'hDEAD;
        cyc(); MemAck = 0; #2;
        chk("late ack WrEn", WrEn, 1'b0);
        chk("late ack MemReq", MemReq, 1'b0);

        // Ex vs wb priority on Rt
        cyc(); ex_alu(3'd4, 16'h0001);
        cyc(); ex_alu(3'd4, 16'h0002); DecRt = 3'd4; #2;
        chk("byp ForwardRt", ForwardRt, 1'b1);
`ifdef WB_EX_BYPASS_EN
        chk("byp RtForwarding", RtForwarding, 16'h0002);
`else
        chk("byp RtForwarding", RtForwarding, 16'h0001);
`endif
        cyc(); ex_idle();
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage of the 16-bit pipeline; the write-side counterpart of the decode stage's register-file read path.
- Accepts execute results (ALU results or load requests), performs multi-cycle data-memory loads via req/ack, and drives the register-file write port (WrEn, WrAddr, DataIn).
- Returns forwarding selects and data (ForwardRs/ForwardRt, RsForwarding/RtForwarding) to decode.
- Raises Stall while a load is outstanding.

Parameters:
- DATA_W, 16, datapath width.
- REG_AW, 3, register index width (8 registers, R7 is link).
- MAX_WAIT, 15, maximum MemAck wait cycles before timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ExValid  in  1  execute result/request valid this cycle
- ExIsLoad  in  1  1 = load (ExAddr valid), 0 = ALU result (ExResult valid)
- ExDest  in  REG_AW  destination register
- ExResult  in  DATA_W  ALU result
- ExAddr  in  DATA_W  load address
- MemReq  out  1  data-memory read request
- MemAddr  out  DATA_W  data-memory address
- MemAck  in  1  read data valid
- MemRdData  in  DATA_W  read data
- DecRs  in  REG_AW  decode Rs index (Instruct[10:8])
- DecRt  in  REG_AW  decode Rt index (Instruct[7:5])
- WrEn  out  1  register-file write enable
- WrAddr  out  REG_AW  register-file write index
- DataIn  out  DATA_W  register-file write data
- ForwardRs  out  1  forward select for Rs
- ForwardRt  out  1  forward select for Rt
- RsForwarding  out  DATA_W  forwarded Rs data
- RtForwarding  out  DATA_W  forwarded Rt data
- Stall  out  1  freeze upstream pipeline
- MemTimeout  out  1  sticky load-timeout flag

Behaviour:
- Reset (async, rst=1): state IDLE; wb_valid, WrEn, MemReq, Stall, MemTimeout, ForwardRs, ForwardRt = 0; WrAddr = 0; DataIn, MemAddr, RsForwarding, RtForwarding = 0; wait counter = 0.
- Reset mid-load drops MemReq immediately. A late MemAck is ignored.
- States: IDLE, LOAD_WAIT.
- IDLE, ExValid & !ExIsLoad:
  - Register wb_dest = ExDest, wb_data = ExResult, wb_valid = 1.
  - Next cycle: WrEn = 1, WrAddr = wb_dest, DataIn = wb_data. Latency 1.
  - Back-to-back ALU results give one write per cycle.
  - If ExValid = 0, wb_valid clears the following cycle.
- IDLE, ExValid & ExIsLoad:
  - Register MemAddr = ExAddr and load dest; MemReq = 1 from the next cycle.
  - Go to LOAD_WAIT. The wb_valid write for the previous result still retires that cycle.
- LOAD_WAIT:
  - MemReq held at 1; Stall = 1; ExValid ignored (upstream is frozen).
  - Counter increments each cycle.
  - On MemAck: wb_data = MemRdData, wb_valid = 1; MemReq, Stall = 0 the next cycle; go to IDLE. The write occurs one cycle after MemAck.
  - If MemAck = 0 and counter == MAX_WAIT: MemTimeout = 1 (sticky until rst), wb_data = 16'h0000 written to dest, return to IDLE.
  - MemAck arriving on the same cycle as the timeout wins; no timeout.
- Stall is registered: asserted the cycle MemReq first rises, deasserted the cycle after MemAck.
- Forwarding:
  - ForwardRs = wb_valid & (wb_dest == DecRs); RsForwarding = wb_data. Rt is identical using DecRt.
  - Combinational from wb state and Dec indices.
  - No forwarding from a load in LOAD_WAIT (Stall covers it).
- Address and data widths are unchanged; no arithmetic beyond the counter, which is a ceil(log2(MAX_WAIT+1))-bit saturating count, cleared on entry to LOAD_WAIT.

Optional Feature:
- Macro WB_EX_BYPASS_EN.
- Defined: forwarding also covers the current-cycle ALU result in IDLE.
  - ForwardRs = 1 when ExValid & !ExIsLoad & ExDest == DecRs, with RsForwarding = ExResult.
  - The Ex match takes priority over a wb match. Rt is identical.
- Undefined: only wb-stage forwarding, as above.

Decomposition:
- Package writeback_pkg holds: state encoding (IDLE = 1'b0, LOAD_WAIT = 1'b1), LINK_REG = 3'd7, and DATA_W/REG_AW defaults.
- One sub-module, fwd_compare: one instance per source operand (Rs, Rt). Inputs: index, wb entry, optional Ex entry. Outputs: select and data.

Test Plan:
- Reset mid-LOAD_WAIT with MemReq = 1: all outputs 0 the same cycle; MemAck 1 cycle after reset release gives no WrEn.
- ALU results dest 3 = 16'h1234 then dest 5 = 16'hBEEF on consecutive cycles: WrEn on cycles N+1 and N+2 with matching WrAddr/DataIn; DecRs = 3 at cycle N+1 gives ForwardRs = 1, RsForwarding = 16'h1234.
- Load ExAddr = 16'h0040, dest 2, MemAck after 4 cycles with 16'hA5A5: MemReq/MemAddr = 16'h0040 for 5 cycles, Stall high throughout, WrEn dest 2 = 16'hA5A5 one cycle after MemAck.
- Load with no MemAck: after MAX_WAIT = 15 wait cycles, MemTimeout = 1 and stays 1; dest written 16'h0000; a subsequent ALU result still writes normally.
- MemAck on the timeout cycle: data written, MemTimeout stays 0.
- With WB_EX_BYPASS_EN: wb holds dest 4 = 16'h0001 and Ex presents dest 4 = 16'h0002 with DecRt = 4: RtForwarding = 16'h0002. Without the macro: 16'h0001.
